// File: rtl/bitwise_pkg.sv
// bitwise_pkg: op encodings shared by the bitwise ALU pipeline.
package bitwise_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOTA = 3'b110,
      OP_ACC  = 3'b111
   } op_e;

endpackage

// File: rtl/bitwise_core.sv
// bitwise_core: combinational op evaluation and result flags.
// Popcount logic exists only when BITWISE_ALU_POPCNT_EN is defined.
module bitwise_core
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] popcnt
);

   always_comb begin
      result = '0;
      unique case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         OP_NOTA: result = ~a;
         OP_ACC:  result = acc ^ a;
      endcase
   end

   assign zero   = (result == '0);
   assign parity = ^result;

`ifdef BITWISE_ALU_POPCNT_EN
   always_comb begin
      popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         popcnt = popcnt + CNT_W'(result[i]);
      end
   end
`else
   assign popcnt = '0;
`endif

endmodule

// File: rtl/bitwise_alu.sv
// bitwise_alu: two-stage valid/ready bitwise ALU with XOR accumulator.
// popcnt is live only when BITWISE_ALU_POPCNT_EN is defined.
module bitwise_alu
   import bitwise_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] popcnt
);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   op_e              r_s1_op;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_parity;
   logic [CNT_W-1:0] r_popcnt;
   logic [WIDTH-1:0] r_acc;

   logic             w_s1_en;
   logic             w_s2_en;
   logic             w_move;
   logic [WIDTH-1:0] w_acc_in;
   logic [WIDTH-1:0] w_result;
   logic             w_zero;
   logic             w_parity;
   logic [CNT_W-1:0] w_popcnt;

   assign w_s2_en  = !r_out_valid || out_ready;
   assign w_s1_en  = !r_s1_valid || w_s2_en;
   assign w_move   = w_s2_en && r_s1_valid;
   // A clear in the same cycle as the move is seen before the XOR.
   assign w_acc_in = acc_clr ? '0 : r_acc;

   bitwise_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .a      (r_s1_a),
      .b      (r_s1_b),
      .op     (r_s1_op),
      .acc    (w_acc_in),
      .result (w_result),
      .zero   (w_zero),
      .parity (w_parity),
      .popcnt (w_popcnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a  <= a;
            r_s1_b  <= b;
            r_s1_op <= op_e'(op);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_parity    <= 1'b0;
         r_popcnt    <= '0;
      end else if (w_s2_en) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_result;
            r_zero   <= w_zero;
            r_parity <= w_parity;
            r_popcnt <= w_popcnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_move && r_s1_op == OP_ACC) begin
         r_acc <= w_result;
      end else if (acc_clr) begin
         r_acc <= '0;
      end
   end

   assign in_ready  = w_s1_en;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign parity    = r_parity;
   assign popcnt    = r_popcnt;

endmodule

// File: tb/tb_bitwise_alu.sv
// tb_bitwise_alu: directed and random checks against a queue model.
module tb_bitwise_alu;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    op;
   logic          acc_clr;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          parity;
   logic [CW-1:0] popcnt;

   int n_chk = 0;
   int n_err = 0;
   int n_acc = 0;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  macc;
   logic [W-1:0]  e_val;
   logic [W-1:0]  r_val;
   logic          hold_v;
   logic [W-1:0]  hold_r;
   logic          hold_z;
   logic          hold_p;
   logic [CW-1:0] hold_c;

   always #5 clk = ~clk;

   bitwise_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .parity    (parity),
      .popcnt    (popcnt)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [2:0] o,
      input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] ac);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         3'd6:    return ~x;
         default: return ac ^ x;
      endcase
   endfunction

   function automatic int pc(input int n);
`ifdef BITWISE_ALU_POPCNT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         macc   = '0;
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, hold_r);
            check("hold_zero", zero, hold_z);
            check("hold_parity", parity, hold_p);
            check("hold_popcnt", popcnt, hold_c);
         end
         hold_v = out_valid && !out_ready;
         hold_r = result;
         hold_z = zero;
         hold_p = parity;
         hold_c = popcnt;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e_val = exp_q.pop_front();
               check("result", result, e_val);
               check("zero", zero, e_val == 0);
               check("parity", parity, ^e_val);
               check("popcnt", popcnt, pc($countones(e_val)));
            end
         end
         if (acc_clr) macc = '0;
         if (in_valid && in_ready) begin
            r_val = ref_op(op, a, b, macc);
            if (op == 3'd7) macc = r_val;
            exp_q.push_back(r_val);
            n_acc++;
         end
      end
   end

   task automatic send(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
      @(posedge clk); #1;
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) break;
         if (i == 49) check("send_timeout", 0, 1);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && !out_valid) break;
         if (i == 299) check("drain_timeout", 0, 1);
      end
   endtask

   task automatic wait_out(input string tag, input logic [W-1:0] exp);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (i == 19) check("out_timeout", 0, 1);
      end
      check(tag, result, exp);
   endtask

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
      a = '0; b = '0; op = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_result", result, 0);
      check("rst_zero", zero, 0);
      check("rst_parity", parity, 0);
      check("rst_popcnt", popcnt, 0);

      send(3'd0, 8'hA5, 8'h0F);
      idle();
      @(negedge clk);
      check("and_lat1", out_valid, 0);
      @(negedge clk);
      check("and_lat2", out_valid, 1);
      check("and_res", result, 8'h05);
      check("and_zero", zero, 0);
      check("and_par", parity, 0);
      check("and_pop", popcnt, pc(2));
      drain();

      send(3'd2, 8'hFF, 8'hFF);
      idle();
      wait_out("xor_res", 8'h00);
      check("xor_zero", zero, 1);
      check("xor_pop", popcnt, 0);
      drain();
      send(3'd6, 8'h3C, W'($urandom));
      idle();
      wait_out("nota_res", 8'hC3);
      drain();
      send(3'd1, 8'hF0, 8'h0F);
      idle();
      wait_out("or_res", 8'hFF);
      check("or_pop", popcnt, pc(8));
      drain();

      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            send(3'd0, W'($urandom), W'($urandom));
            send(3'd1, W'($urandom), W'($urandom));
            send(3'd2, W'($urandom), W'($urandom));
            send(3'd4, W'($urandom), W'($urandom));
            idle();
         end
         begin
            for (int i = 0; i < 50; i++) begin
               @(posedge clk);
               if (n_acc >= base + 2) break;
            end
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", n_acc - base, 4);

      send(3'd7, 8'h0F, W'($urandom));
      idle();
      wait_out("acc1", 8'h0F);
      send(3'd7, 8'hF0, W'($urandom));
      idle();
      wait_out("acc2", 8'hFF);
      send(3'd7, 8'hFF, W'($urandom));
      idle();
      wait_out("acc3", 8'h00);
      drain();
      send(3'd7, 8'h55, 8'h00);
      idle();
      wait_out("acc4", 8'h55);
      drain();
      // Clear lands on the same edge the 0x33 beat moves to stage 2.
      send(3'd7, 8'h33, W'($urandom));
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_clr  = 1'b1;
      @(negedge clk); #1;
      macc = 8'h33;
      exp_q[exp_q.size()-1] = 8'h33;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      wait_out("acc_clr_res", 8'h33);
      drain();

      out_ready = 1'b0;
      send(3'd1, W'($urandom), W'($urandom));
      send(3'd7, W'($urandom), W'($urandom));
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst2_out_valid", out_valid, 0);
      check("rst2_in_ready", in_ready, 1);
      send(3'd7, 8'h01, W'($urandom));
      idle();
      wait_out("rst2_acc", 8'h01);
      drain();

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 4) != 0;
         op        = 3'($urandom);
         a         = W'($urandom);
         b         = W'($urandom);
         out_ready = ($urandom % 3) != 0;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bitwise_alu.md
BITWISE_ALU -- requirements
Module: bitwise_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have derived localparam CNT_W = $clog2(WIDTH+1), popcount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  3  operation select.
REQ-010 SHALL have port acc_clr  input  1  accumulator clear request.
REQ-011 SHALL have port out_valid  output  1  result beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have port zero  output  1  result == 0.
REQ-015 SHALL have port parity  output  1  XOR-reduction of result.
REQ-016 SHALL have port popcnt  output  CNT_W  number of ones in result.

Function
REQ-017 SHALL decode op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT_A, 111 ACC_XOR.
REQ-018 SHALL accept a beat when in_valid && in_ready, capturing a, b and op into stage 1.
REQ-019 SHALL compute the result and flags from stage 1 and register them into stage 2, so out_valid rises exactly 2 cycles after acceptance with no stall.
REQ-020 SHALL use the stage-2 load condition s2_en = !out_valid || out_ready, the stage-1 load condition s1_en = !s1_valid || s2_en, and in_ready = s1_en, sustaining one beat per cycle.
REQ-021 SHALL hold result, zero, parity and popcnt stable while out_valid && !out_ready, with no beat lost, duplicated or reordered.
REQ-022 SHALL, for ACC_XOR, update an internal WIDTH-bit accumulator acc <= acc ^ a exactly once, when the beat moves from stage 1 to stage 2, and return the new acc value as result.
REQ-023 SHALL, when acc_clr is high, clear acc at the clock edge; if a beat moves into stage 2 that same cycle with ACC_XOR, the clear applies first, so result = a and acc <= a.
REQ-024 SHALL ignore b for NOT_A and ACC_XOR.
REQ-025 SHALL ignore in_valid when in_ready is low, and SHALL allow a, b and op to change freely while in_valid is low.

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear the stage-1 valid, out_valid, result, zero, parity, popcnt and acc to 0, discarding all in-flight beats.
REQ-027 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL compile the popcount logic only when macro BITWISE_ALU_POPCNT_EN is defined; popcnt is then the registered count of ones in result.
REQ-029 SHALL, without BITWISE_ALU_POPCNT_EN, keep the popcnt port, drive it constant 0, and leave all other behaviour unchanged.

Structure
REQ-030 SHALL place the op encodings (localparam or enum, 3 bits) in a shared package bitwise_pkg.
REQ-031 SHALL implement the combinational op/flag evaluation in one sub-module, bitwise_core (inputs a, b, op, acc; outputs result, zero, parity, popcnt), with the pipeline registers and the accumulator in bitwise_alu.

Verification (WIDTH=8, macro defined unless stated)
REQ-032 SHALL cover AND with a=0xA5, b=0x0F -> result 0x05, zero 0, parity 0, popcnt 2, out_valid 2 cycles after accept.
REQ-033 SHALL cover XOR with a=0xFF, b=0xFF -> result 0x00, zero 1, parity 0, popcnt 0; and NOT_A with a=0x3C -> result 0xC3.
REQ-034 SHALL cover 4 back-to-back beats with out_ready low for 3 cycles -> in_ready falls after the 2nd accept, the first result holds stable, and all 4 results emerge in order with none lost or duplicated.
REQ-035 SHALL cover ACC_XOR with a=0x0F, 0xF0, 0xFF -> results 0x0F, 0xFF, 0x00; then acc_clr together with ACC_XOR a=0x33 -> result 0x33.
REQ-036 SHALL cover rst asserted with 2 beats in flight -> on the next cycle out_valid 0, in_ready 1, and a following ACC_XOR with a=0x01 returns 0x01.
REQ-037 SHALL cover a build without BITWISE_ALU_POPCNT_EN running OR with a=0xF0, b=0x0F -> result 0xFF, popcnt 0.
